parity_frame_ctrl: RTL



---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_acc.sv | 33 +++
 rtl/parity_frame_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the framed parity checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned PAR_EVEN = 0;
    localparam int unsigned PAR_ODD  = 1;

endpackage

// File: rtl/parity_acc.sv
// Serial parity toggle flop: out flips on every enabled 1; clear wins over enable.
module parity_acc (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic out
);

    logic out_q;
    logic out_d;

    always_comb begin
        out_d = out_q;
        if (clr) begin
            out_d = 1'b0;
        end else if (en) begin
            out_d = out_q ^ in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Framed serial parity checker: collects DATA_BITS bits plus a parity bit after
// a start pulse and reports the word with a registered pass/fail flag.
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ODD       = PAR_EVEN
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in,
    output logic                 busy,
    output logic                 done,
    output logic                 par_err,
    output logic [DATA_BITS-1:0] data
);

    localparam int unsigned CNT_W   = $clog2(DATA_BITS + 1);
    localparam logic        ODD_BIT = (ODD == PAR_ODD);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 par_err_q, par_err_d;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 acc_out;

    parity_acc u_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .in      (in),
        .out     (acc_out)
    );

    // Next-state, datapath updates and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sr_d    = '0;
                    acc_clr = 1'b1;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Shift in from the top so the first bit ends up at the LSB.
                    sr_d   = (sr_q >> 1) | (DATA_BITS'(in) << (DATA_BITS - 1));
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d    = sr_q;
                    par_err_d = acc_out ^ in ^ ODD_BIT;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DATA) || (state_d == PARITY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign par_err = par_err_q;
    assign data    = data_q;

endmodule
